// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package pipe_ctrl_pkg;

  localparam int unsigned REG_W           = 5;
  localparam int unsigned MEM_TIMEOUT_DEF = 16;
  localparam logic [REG_W-1:0] REG_X0     = 5'd0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  // Pipeline register enables/flushes, MSB first in port order
  typedef struct packed {
    logic pc_write;
    logic pc_sel_branch;
    logic ifid_write;
    logic ifid_flush;
    logic idex_write;
    logic idex_flush;
    logic exmem_write;
    logic memwb_write;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  localparam ctrl_t CTRL_RUN = '{pc_write: 1'b1, pc_sel_branch: 1'b0,
                                 ifid_write: 1'b1, ifid_flush: 1'b0,
                                 idex_write: 1'b1, idex_flush: 1'b0,
                                 exmem_write: 1'b1, memwb_write: 1'b1};

  // Redirect squashes the two younger instructions (IF/ID and ID/EX)
  localparam ctrl_t CTRL_BRANCH = '{pc_write: 1'b1, pc_sel_branch: 1'b1,
                                    ifid_write: 1'b1, ifid_flush: 1'b1,
                                    idex_write: 1'b1, idex_flush: 1'b1,
                                    exmem_write: 1'b1, memwb_write: 1'b1};

  // Hold PC and IF/ID, push a bubble into ID/EX, let older stages drain
  localparam ctrl_t CTRL_STALL = '{pc_write: 1'b0, pc_sel_branch: 1'b0,
                                   ifid_write: 1'b0, ifid_flush: 1'b0,
                                   idex_write: 1'b1, idex_flush: 1'b1,
                                   exmem_write: 1'b1, memwb_write: 1'b1};

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard inputs and pipeline control outputs of the sequencer.
// Perf counter signals exist only when PIPE_HAZARD_PERF_EN is defined.
interface pipe_hazard_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_uses_rs2;
  logic             ex_memread;
  logic [REG_W-1:0] ex_rd;
  logic             ex_branch_taken;
  logic             mem_req;
  logic             dmem_ready;

  logic             pc_write;
  logic             pc_sel_branch;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_write;
  logic             idex_flush;
  logic             exmem_write;
  logic             memwb_write;
  logic             mem_timeout;
  logic [1:0]       state_o;
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0]      perf_stall_cycles;
  logic [31:0]      perf_flushes;
`endif

  // Sequencer side
  modport slave (
`ifdef PIPE_HAZARD_PERF_EN
    output perf_stall_cycles, output perf_flushes,
`endif
    input  id_rs1, input id_rs2, input id_uses_rs2, input ex_memread,
    input  ex_rd, input ex_branch_taken, input mem_req, input dmem_ready,
    output pc_write, output pc_sel_branch, output ifid_write, output ifid_flush,
    output idex_write, output idex_flush, output exmem_write, output memwb_write,
    output mem_timeout, output state_o
  );

  // Core datapath side
  modport master (
`ifdef PIPE_HAZARD_PERF_EN
    input  perf_stall_cycles, input perf_flushes,
`endif
    output id_rs1, output id_rs2, output id_uses_rs2, output ex_memread,
    output ex_rd, output ex_branch_taken, output mem_req, output dmem_ready,
    input  pc_write, input pc_sel_branch, input ifid_write, input ifid_flush,
    input  idex_write, input idex_flush, input exmem_write, input memwb_write,
    input  mem_timeout, input state_o
  );

endinterface

// File: rtl/pipe_load_use_detect.sv
// Load-use hazard compare: the load in EX writes a register the ID
// instruction reads. x0 never creates a dependency.
module pipe_load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs2,
  output logic             lu_c
);

  assign lu_c = ex_memread && (ex_rd != REG_X0) &&
                ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: load-use stall, branch redirect, data-memory freeze
// and a sticky memory-timeout watchdog. Controls are combinational from the
// current state so a stall or redirect acts in the cycle it is detected.
// Optional perf counters: define PIPE_HAZARD_PERF_EN.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int unsigned CNT_W       = 8
) (
  input logic               clk,
  input logic               reset,
  pipe_hazard_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  ctrl_t            ctrl_c;
  logic             timeout_c;
  logic             run_eval_c;
  logic             freeze_c;
  logic             stall_c;
  logic             redirect_c;
  logic             lu_c;

  pipe_load_use_detect u_lu (
    .ex_memread  (bus.ex_memread),
    .ex_rd       (bus.ex_rd),
    .id_rs1      (bus.id_rs1),
    .id_rs2      (bus.id_rs2),
    .id_uses_rs2 (bus.id_uses_rs2),
    .lu_c        (lu_c)
  );

  // State and memory-wait counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, wait counter and control mux (ERR > freeze > branch > load-use)
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ctrl_c     = CTRL_IDLE;
    timeout_c  = 1'b0;
    run_eval_c = 1'b0;
    freeze_c   = 1'b0;
    stall_c    = 1'b0;
    redirect_c = 1'b0;

    case (state_q)
      RUN: begin
        if (bus.mem_req && !bus.dmem_ready) begin
          freeze_c = 1'b1;
          state_d  = MEM_WAIT;
          cnt_d    = '0;
        end else begin
          run_eval_c = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (bus.dmem_ready) begin
          run_eval_c = 1'b1;
          state_d    = RUN;
          cnt_d      = '0;
        end else begin
          freeze_c = 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = ERR;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ERR: begin
        timeout_c = 1'b1;
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase

    if (run_eval_c) begin
      if (bus.ex_branch_taken) begin
        ctrl_c     = CTRL_BRANCH;
        redirect_c = 1'b1;
      end else if (lu_c) begin
        ctrl_c  = CTRL_STALL;
        stall_c = 1'b1;
      end else begin
        ctrl_c = CTRL_RUN;
      end
    end
  end

  // Controls are forced idle while reset is held
  assign bus.pc_write      = reset & ctrl_c.pc_write;
  assign bus.pc_sel_branch = reset & ctrl_c.pc_sel_branch;
  assign bus.ifid_write    = reset & ctrl_c.ifid_write;
  assign bus.ifid_flush    = reset & ctrl_c.ifid_flush;
  assign bus.idex_write    = reset & ctrl_c.idex_write;
  assign bus.idex_flush    = reset & ctrl_c.idex_flush;
  assign bus.exmem_write   = reset & ctrl_c.exmem_write;
  assign bus.memwb_write   = reset & ctrl_c.memwb_write;
  assign bus.mem_timeout   = reset & timeout_c;
  assign bus.state_o       = 2'(state_q);

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_flush_q;

  // Stall/redirect event counters; no events are raised in ERR, so they freeze
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (freeze_c || stall_c) perf_stall_q <= perf_stall_q + 32'd1;
      if (redirect_c)          perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign bus.perf_stall_cycles = perf_stall_q;
  assign bus.perf_flushes      = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned TO = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Model: sticky error flag, length of the current freeze run, event counts
  bit          m_err;
  int          m_frz;
  int unsigned m_stall;
  int unsigned m_flush;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [10:0] dut_vec();
    return {bus.pc_write, bus.pc_sel_branch, bus.ifid_write, bus.ifid_flush,
            bus.idex_write, bus.idex_flush, bus.exmem_write, bus.memwb_write,
            bus.mem_timeout, bus.state_o};
  endfunction

  // Expected outputs for this cycle from the rules, then advance the model
  task automatic model_check();
    logic [10:0] e;
    bit          lu;
    int          st;
    lu = bus.ex_memread && (bus.ex_rd != 5'd0) &&
         ((bus.ex_rd == bus.id_rs1) || (bus.id_uses_rs2 && (bus.ex_rd == bus.id_rs2)));
    e = '0;
    if (!reset) begin
      m_err = 1'b0; m_frz = 0; m_stall = 0; m_flush = 0;
    end
`ifdef PIPE_HAZARD_PERF_EN
    check("perf_stall_run", bus.perf_stall_cycles, m_stall);
    check("perf_flush_run", bus.perf_flushes, m_flush);
`endif
    if (!reset) begin
      e = '0;
    end else if (m_err) begin
      e = 11'b00000000_1_10;
    end else begin
      st = (m_frz > 0) ? 1 : 0;
      if (((m_frz > 0) || bus.mem_req) && !bus.dmem_ready) begin
        m_frz++;
        m_stall++;
        if (m_frz == int'(TO) + 1) m_err = 1'b1;
      end else begin
        m_frz = 0;
        if (bus.ex_branch_taken) begin
          e[10:3] = 8'b1111_1111;
          m_flush++;
        end else if (lu) begin
          e[10:3] = 8'b0000_1111;
          m_stall++;
        end else begin
          e[10:3] = 8'b1010_1011;
        end
      end
      e[1:0] = 2'(st);
    end
    check("cycle_outputs", 32'(dut_vec()), 32'(e));
  endtask

  task automatic at_neg();
    @(negedge clk);
    model_check();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_uses_rs2 = 1'b0;
    bus.ex_memread = 1'b0; bus.ex_rd = '0; bus.ex_branch_taken = 1'b0;
    bus.mem_req = 1'b0; bus.dmem_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_in();
    at_neg();
    adv();
    reset = 1'b1;
  endtask

  task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs1);
    bus.ex_memread = 1'b1; bus.ex_rd = rd; bus.id_rs1 = rs1;
  endtask

  initial begin
    reset = 1'b0;
    clear_in();
    // reset state: idle controls even though inputs describe normal RUN
    at_neg();
    check("rst_pc_write", 32'(bus.pc_write), 32'd0);
    check("rst_memwb", 32'(bus.memwb_write), 32'd0);
    check("rst_state", 32'(bus.state_o), 32'd0);
    adv();
    reset = 1'b1;

    // load-use via rs1: one-cycle stall
    set_lu(5'd5, 5'd5);
    at_neg();
    check("lu_pc_write", 32'(bus.pc_write), 32'd0);
    check("lu_ifid_write", 32'(bus.ifid_write), 32'd0);
    check("lu_idex_flush", 32'(bus.idex_flush), 32'd1);
    check("lu_exmem", 32'(bus.exmem_write), 32'd1);
    adv();
    bus.ex_memread = 1'b0;
    at_neg();
    check("lu_done_pc", 32'(bus.pc_write), 32'd1);
    check("lu_done_flush", 32'(bus.idex_flush), 32'd0);
    adv();

    // load-use via rs2 only counts when rs2 is read
    bus.ex_memread = 1'b1; bus.ex_rd = 5'd7; bus.id_rs1 = 5'd1; bus.id_rs2 = 5'd7;
    bus.id_uses_rs2 = 1'b1;
    at_neg();
    check("lu_rs2_pc", 32'(bus.pc_write), 32'd0);
    adv();
    bus.id_uses_rs2 = 1'b0;
    at_neg();
    check("lu_rs2_unused_pc", 32'(bus.pc_write), 32'd1);
    adv();

    // x0 destination never stalls
    clear_in();
    set_lu(5'd0, 5'd0);
    at_neg();
    check("x0_pc_write", 32'(bus.pc_write), 32'd1);
    check("x0_idex_flush", 32'(bus.idex_flush), 32'd0);
    adv();

    // branch wins over a simultaneous load-use
    set_lu(5'd5, 5'd5);
    bus.ex_branch_taken = 1'b1;
    at_neg();
    check("br_sel", 32'(bus.pc_sel_branch), 32'd1);
    check("br_ifid_flush", 32'(bus.ifid_flush), 32'd1);
    check("br_idex_flush", 32'(bus.idex_flush), 32'd1);
    check("br_pc_write", 32'(bus.pc_write), 32'd1);
    check("br_ifid_write", 32'(bus.ifid_write), 32'd1);
    adv();

    // memory wait: 3 not-ready cycles then ready
    clear_in();
    bus.mem_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      at_neg();
      check("mw_state", 32'(bus.state_o), (k == 0) ? 32'd0 : 32'd1);
      check("mw_pc_write", 32'(bus.pc_write), 32'd0);
      check("mw_memwb", 32'(bus.memwb_write), 32'd0);
      adv();
    end
    bus.dmem_ready = 1'b1;
    at_neg();
    check("mw_ready_state", 32'(bus.state_o), 32'd1);
    check("mw_ready_pc", 32'(bus.pc_write), 32'd1);
    check("mw_ready_exmem", 32'(bus.exmem_write), 32'd1);
    adv();
    bus.mem_req = 1'b0;
    at_neg();
    check("mw_back_run", 32'(bus.state_o), 32'd0);
    adv();

    // timeout: ERR after 1 + TO not-ready cycles, sticky until reset
    do_reset();
    bus.mem_req = 1'b1;
    for (int k = 0; k < int'(TO) + 1; k++) begin
      at_neg();
      check("to_wait_state", 32'(bus.state_o), (k == 0) ? 32'd0 : 32'd1);
      check("to_wait_mt", 32'(bus.mem_timeout), 32'd0);
      adv();
    end
    at_neg();
    check("to_err_state", 32'(bus.state_o), 32'd2);
    check("to_err_mt", 32'(bus.mem_timeout), 32'd1);
    check("to_err_pc", 32'(bus.pc_write), 32'd0);
    adv();
    bus.dmem_ready = 1'b1; bus.mem_req = 1'b0; bus.ex_branch_taken = 1'b1;
    for (int k = 0; k < 3; k++) begin
      at_neg();
      check("to_sticky_state", 32'(bus.state_o), 32'd2);
      check("to_sticky_sel", 32'(bus.pc_sel_branch), 32'd0);
      adv();
    end

    // asynchronous reset in the middle of MEM_WAIT
    do_reset();
    bus.mem_req = 1'b1;
    at_neg(); adv();
    at_neg(); adv();
    #2;
    reset = 1'b0;
    #1;
    check("async_state", 32'(bus.state_o), 32'd0);
    check("async_mt", 32'(bus.mem_timeout), 32'd0);
    at_neg();
    adv();
    reset = 1'b1;
    bus.mem_req = 1'b0;
    at_neg();
    check("async_after_state", 32'(bus.state_o), 32'd0);
    check("async_after_pc", 32'(bus.pc_write), 32'd1);
    adv();

`ifdef PIPE_HAZARD_PERF_EN
    // 2 load-use stalls + 3 freeze cycles + 1 branch
    do_reset();
    set_lu(5'd5, 5'd5);
    at_neg(); adv();
    bus.ex_memread = 1'b0;
    at_neg(); adv();
    bus.ex_memread = 1'b1;
    at_neg(); adv();
    bus.ex_memread = 1'b0;
    bus.mem_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      at_neg(); adv();
    end
    bus.dmem_ready = 1'b1;
    at_neg(); adv();
    bus.mem_req = 1'b0; bus.ex_branch_taken = 1'b1;
    at_neg(); adv();
    bus.ex_branch_taken = 1'b0;
    at_neg();
    check("perf_stall_lit", bus.perf_stall_cycles, 32'd5);
    check("perf_flush_lit", bus.perf_flushes, 32'd1);
    adv();
`endif

    // randomized traffic with occasional resets
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      reset               = ($urandom_range(0, 249) == 0) ? 1'b0 : 1'b1;
      bus.id_rs1          = 5'($urandom_range(0, 3));
      bus.id_rs2          = 5'($urandom_range(0, 3));
      bus.id_uses_rs2     = 1'($urandom_range(0, 1));
      bus.ex_memread      = 1'($urandom_range(0, 1));
      bus.ex_rd           = 5'($urandom_range(0, 3));
      bus.ex_branch_taken = ($urandom_range(0, 5) == 0);
      bus.mem_req         = ($urandom_range(0, 2) == 0);
      bus.dmem_ready      = ($urandom_range(0, 9) < 6);
      at_neg();
      adv();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
